// File: rtl/key_stepper.sv
// Pushbutton stepper: synchronises and debounces KEY, steps a 3-bit position on
// each accepted press and auto-repeats while held; SW selects the step direction.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | key released, waiting for the synchronised key to go low
// PRESS_WAIT   | key low, must stay low DEBOUNCE_CYCLES before first step
// HELD         | first step taken, counting REPEAT_DELAY to first repeat
// REPEAT       | auto-repeating, one step every REPEAT_PERIOD cycles
// RELEASE_WAIT | key high, must stay high DEBOUNCE_CYCLES before IDLE
module key_stepper #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic       sw,
    output logic       step,
    output logic [2:0] pos,
    output logic [7:0] LED
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] HELD         = 3'd2;
    localparam logic [2:0] REPEAT       = 3'd3;
    localparam logic [2:0] RELEASE_WAIT = 3'd4;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic             key_m, key_s;
    logic             sw_m, sw_s;
    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
            sw_m  <= 1'b1;
            sw_s  <= 1'b1;
        end else begin
            key_m <= key;
            key_s <= key_m;
            sw_m  <= sw;
            sw_s  <= sw_m;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (!key_s) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer == DB_LAST) begin
                    fire      = 1'b1;
                    state_nxt = HELD;
                    timer_nxt = '0;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end else if (timer == RD_LAST) begin
                    fire      = 1'b1;
                    state_nxt = REPEAT;
                    timer_nxt = '0;
                end
            end
            REPEAT: begin
                if (key_s) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end else if (timer == RP_LAST) begin
                    fire      = 1'b1;
                    timer_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce low restarts the release debounce but never re-arms a repeat.
                if (!key_s) begin
                    timer_nxt = '0;
                end else if (timer == DB_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            step  <= 1'b0;
            pos   <= 3'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            step  <= fire;
            if (fire) pos <= sw_s ? pos + 3'd1 : pos - 3'd1;
        end
    end

    // Position 0 lights the leftmost LED.
    always_comb LED = 8'h80 >> pos;

endmodule

// File: tb/tb_key_stepper.sv
// Scoreboard bench for key_stepper: stimulus queues expected step cycles and
// positions, a negedge monitor pops and compares on every step pulse.
module tb_key_stepper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       sw;
    logic       step;
    logic [2:0] pos;
    logic [7:0] LED;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base;

    typedef struct {
        int         c;
        logic [2:0] p;
    } exp_t;
    exp_t q[$];

    key_stepper #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .CNT_W          (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .sw   (sw),
        .step (step),
        .pos  (pos),
        .LED  (LED)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] p);
        exp_t e;
        e.c = c;
        e.p = p;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every step pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (!$onehot(LED)) begin
                errors++;
                $display("FAIL led_onehot: got %02h, expected one bit set", LED);
            end
            if (q.size() > 0 && q[0].c < cyc) begin
                errors++;
                $display("FAIL missed_step: no step at cycle %0d, expected pos %0d", q[0].c, q[0].p);
                void'(q.pop_front());
            end
            if (step === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step: step at cycle %0d pos %0d, expected none", cyc, pos);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("step_cycle", cyc, e.c);
                    chk("step_pos", int'(pos), int'(e.p));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        key   = 1'b1;
        sw    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step", int'(step), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_led", int'(LED), 8'h80);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_pos", int'(pos), 0);
        chk("idle_led", int'(LED), 8'h80);

        // Single debounced press, forward
        sw   = 1'b1;
        key  = 1'b0;
        base = cyc;
        push(base + 7, 3'd1);
        wait_until(base + 12);
        key = 1'b1;
        repeat (12) @(negedge clk);
        chk("single_pos", int'(pos), 1);
        chk("single_led", int'(LED), 8'h40);

        // Async reset mid-cycle, no clock edge needed
        #2 rst_n = 1'b0;
        #1;
        chk("async_pos", int'(pos), 0);
        chk("async_led", int'(LED), 8'h80);
        chk("async_step", int'(step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bounce shorter than debounce window
        key = 1'b0;
        repeat (3) @(negedge clk);
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        repeat (3) @(negedge clk);
        key = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_pos", int'(pos), 0);

        // Auto-repeat with wrap 7->0
        key  = 1'b0;
        base = cyc;
        push(base + 7,  3'd1);
        push(base + 17, 3'd2);
        push(base + 20, 3'd3);
        push(base + 23, 3'd4);
        push(base + 26, 3'd5);
        push(base + 29, 3'd6);
        push(base + 32, 3'd7);
        push(base + 35, 3'd0);
        push(base + 38, 3'd1);
        wait_until(base + 38);
        key = 1'b1;
        repeat (12) @(negedge clk);
        chk("repeat_pos", int'(pos), 1);
        chk("repeat_led", int'(LED), 8'h40);

        // Reverse wrap 0->7
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sw   = 1'b0;
        key  = 1'b0;
        base = cyc;
        push(base + 7, 3'd7);
        wait_until(base + 9);
        key = 1'b1;
        repeat (12) @(negedge clk);
        chk("reverse_pos", int'(pos), 7);
        chk("reverse_led", int'(LED), 8'h01);

        // Direction flip during repeat
        key  = 1'b0;
        base = cyc;
        push(base + 7,  3'd6);
        push(base + 17, 3'd5);
        push(base + 20, 3'd4);
        push(base + 23, 3'd5);
        push(base + 26, 3'd6);
        wait_until(base + 20);
        sw = 1'b1;
        wait_until(base + 26);
        key = 1'b1;
        repeat (12) @(negedge clk);
        chk("flip_pos", int'(pos), 6);
        chk("flip_led", int'(LED), 8'h02);

        // Release bounce, then a new press right after release debounce ends
        key  = 1'b0;
        base = cyc;
        push(base + 7, 3'd7);
        wait_until(base + 10);
        for (int i = 0; i < 5; i++) begin
            key = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        wait_until(base + 22);
        key  = 1'b0;
        base = cyc;
        push(base + 7, 3'd0);
        wait_until(base + 9);
        key = 1'b1;
        repeat (12) @(negedge clk);
        chk("relbounce_pos", int'(pos), 0);
        chk("relbounce_led", int'(LED), 8'h80);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
